// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage in-order core: stage enables,
// valid bits, load-use bubbles, jump flushes and memory-wait freezes.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             ex_is_jump,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             redirect,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2
  } cause_e;

  logic       id_v_q, id_v_d;
  logic       ex_v_q, ex_v_d;
  logic       mem_v_q, mem_v_d;
  logic       wb_v_q, wb_v_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_ld_q, ex_ld_d;
  cause_e     st_q, st_d;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hit1, hit2, hazard, jump;
  logic c_off, c_wait, c_jmp, c_hz, c_run;

  assign hit1   = id_use_rs1 & (id_rs1 == ex_rd_q);
  assign hit2   = id_use_rs2 & (id_rs2 == ex_rd_q);
  assign hazard = id_v_q & ex_v_q & ex_ld_q
                & (ex_rd_q != 5'd0) & (hit1 | hit2);
  assign jump   = ex_v_q & ex_is_jump;

  // One-hot cause select encoding the fixed priority
  assign c_off  = ~rst;
  assign c_wait = rst & mem_busy;
  assign c_jmp  = rst & ~mem_busy & jump;
  assign c_hz   = rst & ~mem_busy & ~jump & hazard;
  assign c_run  = rst & ~mem_busy & ~jump & ~hazard;

  always_comb begin
    pc_we    = 1'b0;
    ifid_we  = 1'b0;
    idex_we  = 1'b0;
    exmem_we = 1'b0;
    memwb_we = 1'b0;
    redirect = 1'b0;
    id_v_d   = id_v_q;
    ex_v_d   = ex_v_q;
    mem_v_d  = mem_v_q;
    wb_v_d   = wb_v_q;
    ex_rd_d  = ex_rd_q;
    ex_ld_d  = ex_ld_q;
    st_d     = st_q;
    unique case (1'b1)
      c_off: begin
        st_d = RUN;
      end
      c_wait: begin
        st_d = MEMWAIT;
      end
      c_jmp: begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        memwb_we = 1'b1;
        redirect = 1'b1;
        id_v_d   = 1'b0;
        ex_v_d   = 1'b0;
        mem_v_d  = 1'b1;
        wb_v_d   = mem_v_q;
        ex_rd_d  = 5'd0;
        ex_ld_d  = 1'b0;
        st_d     = RUN;
      end
      c_hz: begin
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        memwb_we = 1'b1;
        ex_v_d   = 1'b0;
        mem_v_d  = 1'b1;
        wb_v_d   = mem_v_q;
        ex_rd_d  = 5'd0;
        ex_ld_d  = 1'b0;
        st_d     = LDUSE;
      end
      c_run: begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        memwb_we = 1'b1;
        id_v_d   = if_valid;
        ex_v_d   = id_v_q;
        mem_v_d  = ex_v_q;
        wb_v_d   = mem_v_q;
        ex_rd_d  = id_v_q ? id_rd : 5'd0;
        ex_ld_d  = id_v_q & id_is_load;
        st_d     = RUN;
      end
      default: begin
        st_d = st_q;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (rst && !pc_we && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (redirect && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_v_q  <= 1'b0;
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
      ex_rd_q <= 5'd0;
      ex_ld_q <= 1'b0;
      st_q    <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      id_v_q  <= id_v_d;
      ex_v_q  <= ex_v_d;
      mem_v_q <= mem_v_d;
      wb_v_q  <= wb_v_d;
      ex_rd_q <= ex_rd_d;
      ex_ld_q <= ex_ld_d;
      st_q    <= st_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign id_valid  = id_v_q;
  assign ex_valid  = ex_v_q;
  assign mem_valid = mem_v_q;
  assign wb_valid  = wb_v_q;
  assign state     = st_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
